// File: rtl/bmc_tx_encoder.sv
// USB-PD CC transmitter: 4b5b-encodes nibbles/K-codes behind a 64-bit preamble
// and drives the BMC line (TX_EN/TX_DAT) toward the analog top.
module bmc_tx_encoder #(
  parameter int UI_CLKS  = 40,
  parameter int PRE_BITS = 64
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       tx_start,
  input  logic       tx_abort,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_k,
  input  logic [3:0] in_data,
  input  logic       in_last,
  output logic       TX_EN,
  output logic       TX_DAT,
  output logic       busy,
  output logic       done,
  output logic       err_udr,
  output logic       err_k
);

  // state | meaning
  // IDLE  | line released, waiting for tx_start
  // PRE   | sending alternating preamble
  // DATA  | sending 4b5b symbols
  // TRAIL | line held low for one UI before release
  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA, ST_TRAIL} state_t;

  localparam int CW = $clog2(UI_CLKS);
  localparam int PW = $clog2(PRE_BITS);
  localparam logic [CW-1:0] UI_LAST  = CW'(UI_CLKS - 1);
  localparam logic [CW-1:0] UI_HALF  = CW'(UI_CLKS / 2);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_BITS - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [4:0]    shift_q, shift_d;
  logic          sym_last_q, sym_last_d;
  logic          hold_vld_q, hold_vld_d;
  logic          hold_k_q, hold_k_d;
  logic [3:0]    hold_data_q, hold_data_d;
  logic          hold_last_q, hold_last_d;
  logic          tx_dat_q, tx_dat_d;
  logic          done_q, done_d;
  logic          err_udr_q, err_udr_d;
  logic          err_k_q, err_k_d;

  logic load, hold_take, hold_clr, cur_bit;

  // Code words are written bit4..bit0; bit0 goes on the line first.
  function automatic logic [4:0] enc_4b5b(input logic k, input logic [3:0] d);
    logic [4:0] c;
    c = 5'b01101;
    if (!k) begin
      case (d)
        4'h0: c = 5'b11110;  4'h1: c = 5'b01001;  4'h2: c = 5'b10100;  4'h3: c = 5'b10101;
        4'h4: c = 5'b01010;  4'h5: c = 5'b01011;  4'h6: c = 5'b01110;  4'h7: c = 5'b01111;
        4'h8: c = 5'b10010;  4'h9: c = 5'b10011;  4'hA: c = 5'b10110;  4'hB: c = 5'b10111;
        4'hC: c = 5'b11010;  4'hD: c = 5'b11011;  4'hE: c = 5'b11100;  default: c = 5'b11101;
      endcase
    end else if (!d[3]) begin
      case (d[2:0])
        3'd0: c = 5'b11000;
        3'd1: c = 5'b10001;
        3'd2: c = 5'b00111;
        3'd3: c = 5'b11001;
        3'd5: c = 5'b00110;
        default: c = 5'b01101;
      endcase
    end
    return c;
  endfunction

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sym_last_d  = sym_last_q;
    hold_vld_d  = hold_vld_q;
    hold_k_d    = hold_k_q;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    tx_dat_d    = tx_dat_q;
    done_d      = 1'b0;
    err_udr_d   = 1'b0;
    hold_take   = 1'b0;
    hold_clr    = 1'b0;
    load        = in_valid && !hold_vld_q;
    err_k_d     = load && in_k && (in_data[3] || (in_data[2:0] > 3'd5));
    cur_bit     = (state_q == ST_PRE) ? !pre_cnt_q[0] : shift_q[0];

    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          state_d   = ST_PRE;
          tx_dat_d  = 1'b1;
          clk_cnt_d = UI_LAST;
          pre_cnt_d = PRE_LAST;
        end
      end
      ST_PRE, ST_DATA: begin
        if (tx_abort) begin
          state_d   = ST_TRAIL;
          tx_dat_d  = 1'b0;
          clk_cnt_d = UI_LAST;
          hold_clr  = 1'b1;
        end else if (clk_cnt_q == '0) begin
          clk_cnt_d = UI_LAST;
          tx_dat_d  = !tx_dat_q;
          if (state_q == ST_PRE && pre_cnt_q != '0) begin
            pre_cnt_d = pre_cnt_q - 1'b1;
          end else if (state_q == ST_DATA && bit_cnt_q != 3'd0) begin
            shift_d   = {1'b0, shift_q[4:1]};
            bit_cnt_d = bit_cnt_q - 3'd1;
          end else if (state_q == ST_DATA && sym_last_q) begin
            state_d  = ST_TRAIL;
            tx_dat_d = 1'b0;
          end else if (hold_vld_q) begin
            state_d    = ST_DATA;
            shift_d    = enc_4b5b(hold_k_q, hold_data_q);
            bit_cnt_d  = 3'd4;
            sym_last_d = hold_last_q;
            hold_take  = 1'b1;
          end else begin
            state_d   = ST_TRAIL;
            tx_dat_d  = 1'b0;
            err_udr_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q - 1'b1;
          // mid-bit transition marks a '1'
          if (clk_cnt_q == UI_HALF && cur_bit) tx_dat_d = !tx_dat_q;
        end
      end
      ST_TRAIL: begin
        if (clk_cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // abort clear beats a same-cycle load; a fetch frees the slot for it
    if (hold_clr) begin
      hold_vld_d = 1'b0;
    end else if (load) begin
      hold_vld_d  = 1'b1;
      hold_k_d    = in_k;
      hold_data_d = in_data;
      hold_last_d = in_last;
    end else if (hold_take) begin
      hold_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      sym_last_q  <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_k_q    <= 1'b0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      tx_dat_q    <= 1'b0;
      done_q      <= 1'b0;
      err_udr_q   <= 1'b0;
      err_k_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sym_last_q  <= sym_last_d;
      hold_vld_q  <= hold_vld_d;
      hold_k_q    <= hold_k_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      tx_dat_q    <= tx_dat_d;
      done_q      <= done_d;
      err_udr_q   <= err_udr_d;
      err_k_q     <= err_k_d;
    end
  end

  assign in_ready = !hold_vld_q;
  assign TX_EN    = (state_q != ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign TX_DAT   = tx_dat_q;
  assign done     = done_q;
  assign err_udr  = err_udr_q;
  assign err_k    = err_k_q;

endmodule

// File: tb/tb_bmc_tx_encoder.sv
// Scoreboard bench: a line-level waveform model fills a queue per frame and a
// negedge monitor compares the BMC pins against it.
module tb_bmc_tx_encoder;
  localparam int UI  = 40;
  localparam int PRE = 64;

  logic clk = 1'b0;
  logic srst, tx_start, tx_abort, in_valid, in_k, in_last;
  logic [3:0] in_data;
  logic in_ready, TX_EN, TX_DAT, busy, done, err_udr, err_k;

  always #5 clk = ~clk;

  bmc_tx_encoder #(.UI_CLKS(UI), .PRE_BITS(PRE)) dut (
    .clk(clk), .srst(srst), .tx_start(tx_start), .tx_abort(tx_abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_k(in_k), .in_data(in_data),
    .in_last(in_last), .TX_EN(TX_EN), .TX_DAT(TX_DAT), .busy(busy), .done(done),
    .err_udr(err_udr), .err_k(err_k)
  );

  typedef struct packed {logic dat; logic udr;} exp_t;
  exp_t exp_q[$];
  exp_t cur;

  int n_checks = 0;
  int n_errors = 0;
  int obs_errk = 0;
  int exp_errk = 0;
  bit rst_flag = 1'b0;
  logic prev_en = 1'b0;

  bit       sym_k[$];
  bit [3:0] sym_d[$];

  logic [4:0] data_code[16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011,
                                5'b01110, 5'b01111, 5'b10010, 5'b10011, 5'b10110, 5'b10111,
                                5'b11010, 5'b11011, 5'b11100, 5'b11101};
  logic [4:0] k_code[8] = '{5'b11000, 5'b10001, 5'b00111, 5'b11001, 5'b01101, 5'b00110,
                            5'b01101, 5'b01101};

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [4:0] code_of(input bit k, input bit [3:0] d);
    if (!k) return data_code[d];
    if (d[3]) return 5'b01101;
    return k_code[d[2:0]];
  endfunction

  // Expected line level per clock: every bit starts with a toggle, a '1' toggles again at UI/2.
  task automatic build_wave(input int nsym, input int cut, input bit udr);
    bit   bits[$];
    exp_t w[$];
    logic [4:0] c;
    logic lvl = 1'b0;
    exp_t e;
    for (int i = 0; i < PRE; i++) bits.push_back(i % 2);
    for (int s = 0; s < nsym; s++) begin
      c = code_of(sym_k[s], sym_d[s]);
      for (int j = 0; j < 5; j++) bits.push_back(c[j]);
    end
    foreach (bits[i]) begin
      lvl = !lvl;
      if (!bits[i]) begin
        for (int n = 0; n < UI; n++) w.push_back('{dat: lvl, udr: 1'b0});
      end else begin
        for (int n = 0; n < UI / 2; n++) w.push_back('{dat: lvl, udr: 1'b0});
        lvl = !lvl;
        for (int n = 0; n < UI / 2; n++) w.push_back('{dat: lvl, udr: 1'b0});
      end
    end
    if (cut >= 0) while (w.size() > cut + 1) void'(w.pop_back());
    foreach (w[i]) exp_q.push_back(w[i]);
    for (int n = 0; n < UI; n++) begin
      e.dat = 1'b0;
      e.udr = (n == 0) ? udr : 1'b0;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (err_k === 1'b1) obs_errk++;
    if (TX_EN === 1'b1) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_tx_en", 1, 0);
      end else begin
        cur = exp_q.pop_front();
        check({TX_DAT, err_udr, busy, done} == {cur.dat, cur.udr, 2'b10}, "line_sample",
              {TX_DAT, err_udr, busy, done}, {cur.dat, cur.udr, 2'b10});
      end
    end else if (prev_en === 1'b1) begin
      if (rst_flag) begin
        check({done, TX_DAT, busy, in_ready} == 4'b0001, "reset_end",
              {done, TX_DAT, busy, in_ready}, 4'b0001);
        exp_q.delete();
      end else begin
        check(done === 1'b1 && busy === 1'b0 && TX_DAT === 1'b0 && exp_q.size() == 0,
              "frame_end_done_len", {done, 16'(exp_q.size())}, {1'b1, 16'd0});
      end
    end
    prev_en = TX_EN;
  end

  task automatic load_sym(input bit k, input bit [3:0] d, input bit last);
    int w = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_k = k; in_data = d; in_last = last;
    @(negedge clk);
    while (!in_ready && w < 6000) begin
      @(negedge clk);
      w++;
    end
    check(w < 6000, "load_timeout", w, 6000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (k && (d[3] || d[2:0] > 3'd5)) exp_errk++;
  endtask

  task automatic start_frame();
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    @(negedge clk);
    check(TX_EN === 1'b1, "start_tx_en", TX_EN, 1);
  endtask

  task automatic wait_end();
    int w = 0;
    while (TX_EN === 1'b1 && w < 10000) begin
      @(negedge clk);
      w++;
    end
    check(w < 10000, "frame_timeout", w, 10000);
  endtask

  task automatic post_checks();
    repeat (3) @(negedge clk);
    check(in_ready === 1'b1 && busy === 1'b0, "idle_ready", {in_ready, busy}, 2'b10);
    check(obs_errk == exp_errk, "err_k_count", obs_errk, exp_errk);
  endtask

  // kind: 0 normal, 1 underrun, 2 abort after sample abort_at, 3 reset mid-DATA
  task automatic run_frame(input int kind, input int abort_at);
    int n = sym_k.size();
    case (kind)
      0: build_wave(n, -1, 1'b0);
      1: build_wave(n, -1, 1'b1);
      2: build_wave(1, abort_at, 1'b0);
      default: build_wave(n, -1, 1'b0);
    endcase
    load_sym(sym_k[0], sym_d[0], kind == 0 && n == 1);
    start_frame();
    if (kind == 2) begin
      repeat (abort_at) @(posedge clk);
      #1 tx_abort = 1'b1;
      @(posedge clk); #1;
      tx_abort = 1'b0;
    end else begin
      for (int s = 1; s < n; s++) load_sym(sym_k[s], sym_d[s], kind != 1 && s == n - 1);
      if (kind == 0 && n >= 2) begin
        @(posedge clk); #1 tx_start = 1'b1;
        @(posedge clk); #1 tx_start = 1'b0;
      end
      if (kind == 3) begin
        repeat (30) @(posedge clk);
        #1 rst_flag = 1'b1; srst = 1'b1;
        @(posedge clk); #1 srst = 1'b0;
      end
    end
    wait_end();
    post_checks();
    rst_flag = 1'b0;
  endtask

  task automatic set_syms(input int n, input bit [4:0] a, input bit [4:0] b, input bit [4:0] c,
                          input bit [4:0] d4);
    bit [4:0] v[4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d4;
    sym_k.delete(); sym_d.delete();
    for (int i = 0; i < n; i++) begin
      sym_k.push_back(v[i][4]);
      sym_d.push_back(v[i][3:0]);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, n, a;
    srst = 1'b1; tx_start = 1'b0; tx_abort = 1'b0; in_valid = 1'b0;
    in_k = 1'b0; in_data = 4'h0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({TX_EN, TX_DAT, busy, done, err_udr, err_k, in_ready} == 7'b0000001, "reset_state",
          {TX_EN, TX_DAT, busy, done, err_udr, err_k, in_ready}, 7'b0000001);
    @(posedge clk); #1 srst = 1'b0;

    // Sync-1 x3, Sync-2, 0x5, 0xA, EOP(last): preamble + encoding + trailer
    sym_k = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    sym_d = '{4'd0, 4'd0, 4'd0, 4'd1, 4'h5, 4'hA, 4'd4};
    run_frame(0, 0);
    set_syms(1, 5'h10, 0, 0, 0);
    run_frame(1, 0);
    set_syms(1, 5'h10, 0, 0, 0);
    run_frame(2, 10 * UI + 5);
    set_syms(1, 5'h17, 0, 0, 0);
    run_frame(0, 0);
    set_syms(2, 5'h10, 5'h03, 0, 0);
    run_frame(3, 0);
    set_syms(1, 5'h1C, 0, 0, 0);
    run_frame(2, 0);

    for (int f = 0; f < 6; f++) begin
      kind = $urandom_range(0, 2);
      n = (kind == 2) ? 1 : $urandom_range(1, 4);
      sym_k.delete(); sym_d.delete();
      for (int i = 0; i < n; i++) begin
        sym_k.push_back(1'($urandom_range(0, 1)));
        sym_d.push_back(4'($urandom_range(0, 15)));
      end
      a = $urandom_range(0, 2700);
      run_frame(kind, a);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
